// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register of the RV32I core.
package id_ex_stage_reg_pkg;

   localparam int XLEN      = 32;
   localparam int ALUOP_W   = 4;
   localparam int REG_W     = 5;
   localparam int CNT_W_DEF = 16;

   // ALU operation encodings carried in alu_op
   localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd2;
   localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd3;
   localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd4;
   localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd5;
   localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd8;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd9;
   localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd10;

   // Everything the EX stage sees about one instruction slot
   typedef struct packed {
      logic               valid;
      logic [XLEN-1:0]    pc;
      logic [REG_W-1:0]   rs1;
      logic [REG_W-1:0]   rs2;
      logic [REG_W-1:0]   rd;
      logic [XLEN-1:0]    rs1_data;
      logic [XLEN-1:0]    rs2_data;
      logic [XLEN-1:0]    imm;
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic               branch;
      logic               jump;
   } ex_word_t;

   // A bubble is the all-zero word: no side effects, and rd/rs = x0 so
   // the forwarding unit can never match against it.
   localparam ex_word_t EX_BUBBLE = '0;

   // True when a producer writing rd would feed a consumer reading rs.
   // x0 is hard-wired to zero, so it never creates a dependency.
   function automatic logic reg_dep(input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
      return (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs, EX-side outputs and hazard status of the ID/EX register.
interface id_ex_stage_reg_if #(parameter int CNT_W = 16);
   import id_ex_stage_reg_pkg::*;

   // pipeline control
   logic               hold;
   logic               flush;

   // instruction arriving from ID
   logic               id_valid;
   logic [XLEN-1:0]    id_pc;
   logic [REG_W-1:0]   id_rs1;
   logic [REG_W-1:0]   id_rs2;
   logic [REG_W-1:0]   id_rd;
   logic               id_uses_rs2;
   logic [XLEN-1:0]    id_rs1_data;
   logic [XLEN-1:0]    id_rs2_data;
   logic [XLEN-1:0]    id_imm;
   logic [ALUOP_W-1:0] id_alu_op;
   logic               id_alu_src;
   logic               id_mem_read;
   logic               id_mem_write;
   logic               id_reg_write;
   logic               id_mem_to_reg;
   logic               id_branch;
   logic               id_jump;

   // instruction presented to EX
   logic               ex_valid;
   logic [XLEN-1:0]    ex_pc;
   logic [REG_W-1:0]   ex_rs1;
   logic [REG_W-1:0]   ex_rs2;
   logic [REG_W-1:0]   ex_rd;
   logic [XLEN-1:0]    ex_rs1_data;
   logic [XLEN-1:0]    ex_rs2_data;
   logic [XLEN-1:0]    ex_imm;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic               ex_alu_src;
   logic               ex_mem_read;
   logic               ex_mem_write;
   logic               ex_reg_write;
   logic               ex_mem_to_reg;
   logic               ex_branch;
   logic               ex_jump;

   // hazard status
   logic               load_use_stall;
   logic [CNT_W-1:0]   stall_count;

   // driver side: the ID stage / pipeline controller
   modport master (
      output hold, flush,
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs2,
      output id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src,
      output id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
      output id_branch, id_jump,
      input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd,
      input  ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_op, ex_alu_src,
      input  ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
      input  ex_branch, ex_jump,
      input  load_use_stall, stall_count
   );

   // the pipeline register itself
   modport slave (
      input  hold, flush,
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs2,
      input  id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src,
      input  id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
      input  id_branch, id_jump,
      output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd,
      output ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_op, ex_alu_src,
      output ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
      output ex_branch, ex_jump,
      output load_use_stall, stall_count
   );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: a load in EX whose rd feeds the instruction in ID.
module id_ex_stage_reg_load_use_detect
   import id_ex_stage_reg_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs2,
   input  logic             flush,
   output logic             load_use_stall
);

   logic load_in_ex;
   logic rs1_dep;
   logic rs2_dep;

   // A flushed ID instruction is dead, so it must not freeze the front end.
   always_comb begin
      load_in_ex     = ex_valid & ex_mem_read;
      rs1_dep        = reg_dep(ex_rd, id_rs1);
      rs2_dep        = id_uses_rs2 & reg_dep(ex_rd, id_rs2);
      load_use_stall = load_in_ex & id_valid & (rs1_dep | rs2_dep) & ~flush;
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and stall counter.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   id_ex_stage_reg_if.slave  bus
);

   ex_word_t         ex_q;
   ex_word_t         id_word;
   logic [CNT_W-1:0] cnt_q;
   logic             stall;

   // Pack the ID slot into the word that would be loaded on a normal cycle
   always_comb begin
      id_word            = EX_BUBBLE;
      id_word.valid      = 1'b1;
      id_word.pc         = bus.id_pc;
      id_word.rs1        = bus.id_rs1;
      id_word.rs2        = bus.id_rs2;
      id_word.rd         = bus.id_rd;
      id_word.rs1_data   = bus.id_rs1_data;
      id_word.rs2_data   = bus.id_rs2_data;
      id_word.imm        = bus.id_imm;
      id_word.alu_op     = bus.id_alu_op;
      id_word.alu_src    = bus.id_alu_src;
      id_word.mem_read   = bus.id_mem_read;
      id_word.mem_write  = bus.id_mem_write;
      id_word.reg_write  = bus.id_reg_write;
      id_word.mem_to_reg = bus.id_mem_to_reg;
      id_word.branch     = bus.id_branch;
      id_word.jump       = bus.id_jump;
   end

   id_ex_stage_reg_load_use_detect u_detect (
      .ex_valid       (ex_q.valid),
      .ex_mem_read    (ex_q.mem_read),
      .ex_rd          (ex_q.rd),
      .id_valid       (bus.id_valid),
      .id_rs1         (bus.id_rs1),
      .id_rs2         (bus.id_rs2),
      .id_uses_rs2    (bus.id_uses_rs2),
      .flush          (bus.flush),
      .load_use_stall (stall)
   );

   // Priority: reset, flush (beats hold so a killed op never survives a
   // freeze), hold, load-use bubble, empty ID slot, normal load.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= EX_BUBBLE;
         cnt_q <= '0;
      end else if (bus.flush) begin
         ex_q  <= EX_BUBBLE;
      end else if (!bus.hold) begin
         if (stall) begin
            ex_q <= EX_BUBBLE;
            if (cnt_q != {CNT_W{1'b1}})
               cnt_q <= cnt_q + CNT_W'(1);
         end else if (!bus.id_valid) begin
            ex_q <= EX_BUBBLE;
         end else begin
            ex_q <= id_word;
         end
      end
   end

   // Registered EX view and hazard status
   assign bus.ex_valid       = ex_q.valid;
   assign bus.ex_pc          = ex_q.pc;
   assign bus.ex_rs1         = ex_q.rs1;
   assign bus.ex_rs2         = ex_q.rs2;
   assign bus.ex_rd          = ex_q.rd;
   assign bus.ex_rs1_data    = ex_q.rs1_data;
   assign bus.ex_rs2_data    = ex_q.rs2_data;
   assign bus.ex_imm         = ex_q.imm;
   assign bus.ex_alu_op      = ex_q.alu_op;
   assign bus.ex_alu_src     = ex_q.alu_src;
   assign bus.ex_mem_read    = ex_q.mem_read;
   assign bus.ex_mem_write   = ex_q.mem_write;
   assign bus.ex_reg_write   = ex_q.reg_write;
   assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
   assign bus.ex_branch      = ex_q.branch;
   assign bus.ex_jump        = ex_q.jump;
   assign bus.load_use_stall = stall;
   assign bus.stall_count    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: each cycle the stimulus pushes the
// hand-derived EX view it expects; a monitor pops and compares at negedge.
module tb_id_ex_stage_reg;
   import id_ex_stage_reg_pkg::*;

   localparam int CNT_W = 4;  // small counter so saturation is reachable quickly

   logic clk;
   logic rst;

   id_ex_stage_reg_if #(.CNT_W(CNT_W)) bus ();

   id_ex_stage_reg #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // payload fields derived from an 8-bit tag so each instruction is distinct
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    rs1_data;
      logic [XLEN-1:0]    rs2_data;
      logic [XLEN-1:0]    imm;
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic               branch;
      logic               jump;
   } pl_t;

   typedef struct {
      logic             stall;
      logic [7:0]       tag;    // 0 = bubble expected in EX
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic             mr;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic pl_t payload(input logic [7:0] t);
      pl_t p;
      p.pc         = 32'h0000_1000 + {22'd0, t, 2'b00};
      p.rs1_data   = {4{t}};
      p.rs2_data   = ~{4{t}};
      p.imm        = {{24{t[7]}}, t};
      p.alu_op     = t[7:4];
      p.alu_src    = t[4];
      p.mem_write  = t[5];
      p.reg_write  = t[0];
      p.mem_to_reg = t[1];
      p.branch     = t[2];
      p.jump       = t[3];
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, h, f, v, input logic [4:0] rs1, rs2, rd,
                        input logic u2, mr, input logic [7:0] tag);
      pl_t p;
      p = payload(tag);
      rst               = r;
      bus.hold          = h;
      bus.flush         = f;
      bus.id_valid      = v;
      bus.id_rs1        = rs1;
      bus.id_rs2        = rs2;
      bus.id_rd         = rd;
      bus.id_uses_rs2   = u2;
      bus.id_mem_read   = mr;
      bus.id_pc         = p.pc;
      bus.id_rs1_data   = p.rs1_data;
      bus.id_rs2_data   = p.rs2_data;
      bus.id_imm        = p.imm;
      bus.id_alu_op     = p.alu_op;
      bus.id_alu_src    = p.alu_src;
      bus.id_mem_write  = p.mem_write;
      bus.id_reg_write  = p.reg_write;
      bus.id_mem_to_reg = p.mem_to_reg;
      bus.id_branch     = p.branch;
      bus.id_jump       = p.jump;
   endtask

   // one cycle: apply inputs, record what EX must show during this cycle
   task automatic step(input logic r, h, f, v, input logic [4:0] rs1, rs2, rd,
                       input logic u2, mr, input logic [7:0] tag,
                       input logic es, input logic [7:0] et,
                       input logic [4:0] ers1, ers2, erd, input logic emr, input int ecnt);
      exp_t e;
      drive(r, h, f, v, rs1, rs2, rd, u2, mr, tag);
      e.stall = es; e.tag = et; e.rs1 = ers1; e.rs2 = ers2; e.rd = erd;
      e.mr = emr; e.cnt = ecnt[CNT_W-1:0];
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // monitor: compare the presented EX state and hazard outputs
   initial begin
      exp_t e;
      pl_t  p;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            p = (e.tag == 8'd0) ? pl_t'(0) : payload(e.tag);
            chk("load_use_stall", 32'(bus.load_use_stall), 32'(e.stall));
            chk("stall_count",    32'(bus.stall_count),    32'(e.cnt));
            chk("ex_valid",       32'(bus.ex_valid),       32'(e.tag != 8'd0));
            chk("ex_rs1",         32'(bus.ex_rs1),         32'(e.rs1));
            chk("ex_rs2",         32'(bus.ex_rs2),         32'(e.rs2));
            chk("ex_rd",          32'(bus.ex_rd),          32'(e.rd));
            chk("ex_mem_read",    32'(bus.ex_mem_read),    32'(e.mr));
            chk("ex_pc",          bus.ex_pc,               p.pc);
            chk("ex_rs1_data",    bus.ex_rs1_data,         p.rs1_data);
            chk("ex_rs2_data",    bus.ex_rs2_data,         p.rs2_data);
            chk("ex_imm",         bus.ex_imm,              p.imm);
            chk("ex_ctrl", 32'({bus.ex_alu_op, bus.ex_alu_src, bus.ex_mem_write, bus.ex_reg_write,
                                bus.ex_mem_to_reg, bus.ex_branch, bus.ex_jump}),
                           32'({p.alu_op, p.alu_src, p.mem_write, p.reg_write,
                                p.mem_to_reg, p.branch, p.jump}));
         end
      end
   end

   initial begin
      int c;
      // reset held with a busy ID slot; first edge clears the register
      drive(1, 0, 0, 1, 5'd1, 5'd2, 5'd3, 1, 1, 8'h11);
      @(posedge clk); #1;
      //   r h f v rs1 rs2 rd u2 mr tag    | stall tag  rs1 rs2 rd mr cnt
      step(1,0,0,1, 1, 2, 3, 1, 1, 8'h11,  0, 8'h00,  0, 0, 0, 0, 0);  // 2nd reset cycle
      step(0,0,0,1, 1, 0, 5, 0, 1, 8'h21,  0, 8'h00,  0, 0, 0, 0, 0);  // lw x5
      step(0,0,0,1, 5, 1, 6, 1, 0, 8'h22,  1, 8'h21,  1, 0, 5, 1, 0);  // add x6,x5,x1 stalls
      step(0,0,0,1, 5, 1, 6, 1, 0, 8'h22,  0, 8'h00,  0, 0, 0, 0, 1);  // bubble in EX
      step(0,0,0,1, 2, 0, 5, 0, 1, 8'h23,  0, 8'h22,  5, 1, 6, 0, 1);  // add arrives; lw x5
      step(0,0,0,1, 7, 5, 0, 1, 0, 8'h24,  1, 8'h23,  2, 0, 5, 1, 1);  // sw x5 via rs2 stalls
      step(0,0,0,1, 7, 5, 0, 1, 0, 8'h24,  0, 8'h00,  0, 0, 0, 0, 2);
      step(0,0,0,1, 3, 0, 5, 0, 1, 8'h25,  0, 8'h24,  7, 5, 0, 0, 2);  // lw x5
      step(0,0,0,1, 9, 5, 8, 0, 0, 8'h26,  0, 8'h25,  3, 0, 5, 1, 2);  // addi rs2 field ignored
      step(0,0,0,1, 4, 0, 5, 0, 1, 8'h27,  0, 8'h26,  9, 5, 8, 0, 2);  // lw x5
      step(0,1,1,1, 5, 1, 6, 1, 0, 8'h28,  0, 8'h27,  4, 0, 5, 1, 2);  // flush+hold beats stall
      step(0,0,0,1,10,11,12, 1, 0, 8'h29,  0, 8'h00,  0, 0, 0, 0, 2);  // flushed bubble
      step(0,1,0,1,13,14,15, 1, 0, 8'h2A,  0, 8'h29, 10,11,12, 0, 2);  // hold x3, ID changing
      step(0,1,0,1,16,17,18, 0, 0, 8'h2B,  0, 8'h29, 10,11,12, 0, 2);
      step(0,1,0,1,19,20,21, 1, 1, 8'h2C,  0, 8'h29, 10,11,12, 0, 2);
      step(0,0,0,1, 1, 2, 3, 1, 0, 8'h2D,  0, 8'h29, 10,11,12, 0, 2);  // hold drops
      step(0,0,0,0, 4, 5, 6, 1, 1, 8'h2E,  0, 8'h2D,  1, 2, 3, 0, 2);  // invalid ID slot
      step(0,0,0,1, 1, 0, 7, 0, 1, 8'h30,  0, 8'h00,  0, 0, 0, 0, 2);  // lw x7
      step(0,1,0,1, 7, 0, 9, 1, 0, 8'h31,  1, 8'h30,  1, 0, 7, 1, 2);  // stall seen under hold
      step(0,0,0,1, 7, 0, 9, 1, 0, 8'h31,  1, 8'h30,  1, 0, 7, 1, 2);  // no count while held
      step(0,0,0,1, 7, 0, 9, 1, 0, 8'h31,  0, 8'h00,  0, 0, 0, 0, 3);
      // repeated load-use pairs drive the counter into saturation
      c = 3;
      for (int k = 0; k < 15; k++) begin
         if (k == 0)
            step(0,0,0,1, 1, 0, 5, 0, 1, 8'h40 + 8'(k),  0, 8'h31, 7, 0, 9, 0, c);
         else
            step(0,0,0,1, 1, 0, 5, 0, 1, 8'h40 + 8'(k),  0, 8'h00, 0, 0, 0, 0, c);
         step(0,0,0,1, 5, 0, 6, 1, 0, 8'h60 + 8'(k),  1, 8'h40 + 8'(k), 1, 0, 5, 1, c);
         c = (c == 15) ? 15 : c + 1;
      end
      step(0,0,0,1, 1, 0, 0, 0, 1, 8'h50,  0, 8'h00,  0, 0, 0, 0, 15); // lw x0
      step(0,0,0,1, 0, 0, 6, 1, 0, 8'h51,  0, 8'h50,  1, 0, 0, 1, 15); // use of x0: no stall
      step(0,0,0,0, 0, 0, 0, 0, 0, 8'h00,  0, 8'h51,  0, 0, 6, 0, 15);
      step(1,0,0,1, 1, 0, 5, 0, 1, 8'h52,  0, 8'h00,  0, 0, 0, 0, 15); // reset clears counter
      step(0,0,0,0, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00,  0, 0, 0, 0, 0);
      // let the monitor drain, bounded
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
